// File: rtl/frame_arbiter_pkg.sv
// Shared constants and types for the frame arbiter: port count, FSM states,
// stubbing modes and the Avalon-MM register map.
package frame_arbiter_pkg;

    localparam int FA_NUM_PORTS = 4;
    localparam int FA_DATA_W    = 16;

    // Stubbing modes: passthrough wires port 0 straight to egress
    localparam int STUBBING_PASSTHROUGH = 0;
    localparam int STUBBING_FUNCTIONAL  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_GAP  = 2'd2
    } fa_state_e;

    // Register map
    localparam logic [7:0] ADDR_ENABLE = 8'h00;
    localparam logic [7:0] ADDR_GAP    = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
    localparam logic [7:0] ADDR_CLEAR  = 8'h03;
    localparam logic [7:0] ADDR_COUNT0 = 8'h04;
    localparam logic [7:0] ADDR_COUNT1 = 8'h05;
    localparam logic [7:0] ADDR_COUNT2 = 8'h06;
    localparam logic [7:0] ADDR_COUNT3 = 8'h07;

    // Status byte layout: {5'b0, busy, grant[1:0]}
    function automatic logic [7:0] status_byte(input logic busy, input logic [1:0] grant);
        return {5'b00000, busy, grant};
    endfunction

endpackage

// File: rtl/frame_arbiter_rr_arbiter.sv
// Combinational 4-way rotating-priority picker: the search starts one past
// the previous winner, so every requester is served within four grants.
module rr_arbiter
    import frame_arbiter_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    logic       found;
    logic [1:0] idx;

    // Scan (last_grant+1 .. last_grant+4) mod 4 and take the first requester
    always_comb begin
        grant_o = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last_grant_i + i[1:0];
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/frame_arbiter.sv
// Frame-granular round-robin arbiter: four AXI-Stream ingress ports share one
// egress; a granted port keeps egress until its tlast beat handshakes, then an
// optional programmable idle gap is inserted. Configuration, status and
// per-port frame counters live behind a small Avalon-MM slave.
module frame_arbiter
    import frame_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = FA_NUM_PORTS,
    parameter int STUBBING  = STUBBING_PASSTHROUGH
)(
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic [7:0]                writedata,
    input  logic                      write,
    input  logic                      chipselect,
    input  logic [7:0]                address,
    input  logic                      read,
    output logic [7:0]                readdata,

    input  logic [NUM_PORTS*16-1:0]   in_tdata,
    input  logic [NUM_PORTS-1:0]      in_tvalid,
    input  logic [NUM_PORTS-1:0]      in_tlast,
    output logic [NUM_PORTS-1:0]      in_tready,

    output logic [15:0]               out_tdata,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    input  logic                      out_tready
);

    localparam bit ARB_EN = (STUBBING != STUBBING_PASSTHROUGH);

    fa_state_e   state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_grant_q;
    logic [7:0]  gap_cnt_q;

    logic [3:0]  enable_mask_q;
    logic [7:0]  gap_cycles_q;
    logic [7:0]  frame_count_q [FA_NUM_PORTS];
    logic [7:0]  frame_count_d [FA_NUM_PORTS];
    logic [7:0]  readdata_q;
    logic [7:0]  rd_data;

    logic [1:0]  win_grant;
    logic        win_valid;
    logic        tlast_hs;
    logic [1:0]  done_port;
    logic        csr_wr;
    logic        clear_cnt;

    assign csr_wr    = chipselect & write;
    assign clear_cnt = csr_wr && (address == ADDR_CLEAR);
    assign tlast_hs  = out_tvalid & out_tready & out_tlast;
    assign done_port = ARB_EN ? grant_q : 2'd0;
    assign readdata  = readdata_q;

    rr_arbiter u_rr_arbiter (
        .req_i        (in_tvalid & enable_mask_q),
        .last_grant_i (last_grant_q),
        .grant_o      (win_grant),
        .valid_o      (win_valid)
    );

    // Egress mux; everything is forced quiet while reset_n is low so a frame
    // in flight is cut without a tlast
    always_comb begin
        out_tdata  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        in_tready  = '0;
        if (reset_n) begin
            if (!ARB_EN) begin
                out_tdata    = in_tdata[15:0];
                out_tvalid   = in_tvalid[0];
                out_tlast    = in_tlast[0];
                in_tready[0] = out_tready;
            end else if (state_q == ST_FWD) begin
                out_tdata          = in_tdata[32'(grant_q)*16 +: 16];
                out_tvalid         = in_tvalid[grant_q];
                out_tlast          = in_tlast[grant_q];
                in_tready[grant_q] = out_tready;
            end
        end
    end

    // Arbitration FSM: IDLE picks a winner, FWD owns egress until tlast, GAP
    // holds egress idle for gap_cycles cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            gap_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ARB_EN && win_valid) begin
                        grant_q      <= win_grant;
                        last_grant_q <= win_grant;
                        state_q      <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (tlast_hs) begin
                        if (gap_cycles_q != 8'd0) begin
                            gap_cnt_q <= gap_cycles_q;
                            state_q   <= ST_GAP;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - 8'd1;
                    if (gap_cnt_q == 8'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_mask_q <= 4'hF;
            gap_cycles_q  <= '0;
        end else if (csr_wr) begin
            if (address == ADDR_ENABLE) enable_mask_q <= writedata[3:0];
            if (address == ADDR_GAP)    gap_cycles_q  <= writedata;
        end
    end

    // Per-port completed-frame counters; a clear beats a same-cycle increment
    always_comb begin
        for (int unsigned p = 0; p < FA_NUM_PORTS; p++) begin
            frame_count_d[p] = frame_count_q[p];
            if (clear_cnt) begin
                frame_count_d[p] = '0;
            end else if (tlast_hs && (done_port == p[1:0])) begin
                frame_count_d[p] = frame_count_q[p] + 8'd1;
            end
        end
    end

    // Counter storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned p = 0; p < FA_NUM_PORTS; p++) begin
                frame_count_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < FA_NUM_PORTS; p++) begin
                frame_count_q[p] <= frame_count_d[p];
            end
        end
    end

    // Register read mux; unmapped and write-only addresses read as zero
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_ENABLE: rd_data = {4'b0000, enable_mask_q};
            ADDR_GAP:    rd_data = gap_cycles_q;
            ADDR_STATUS: rd_data = status_byte(state_q != ST_IDLE, grant_q);
            ADDR_COUNT0,
            ADDR_COUNT1,
            ADDR_COUNT2,
            ADDR_COUNT3: rd_data = frame_count_q[address[1:0]];
            default:     rd_data = '0;
        endcase
    end

    // Registered read data, zero whenever no read is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= (chipselect && read) ? rd_data : 8'h00;
        end
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: scripted frame sources, an egress beat
// logger and hand-computed expected beat sequences, gaps and register values.
module tb_frame_arbiter;
    import frame_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  writedata, address, readdata;
    logic        write, chipselect, read;
    logic [63:0] in_tdata;
    logic [3:0]  in_tvalid, in_tlast, in_tready;
    logic [15:0] out_tdata;
    logic        out_tvalid, out_tlast, out_tready;

    int unsigned checks;
    int unsigned failures;

    // Source bookkeeping: main process owns launched/src_len, source owns sent/beat
    int unsigned launched [4];
    int unsigned src_len  [4];
    int unsigned sent     [4];
    int unsigned beat     [4];
    logic        tog;
    logic [3:0]  hs;

    logic [16:0] log_q [$];
    logic [16:0] exp_q [$];
    int unsigned gap_log [$];
    int unsigned viol;
    int unsigned cmp_ptr;
    logic        after_last;
    int unsigned idle_run;

    always #5 clk = ~clk;

    frame_arbiter #(.NUM_PORTS(4), .STUBBING(STUBBING_FUNCTIONAL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .writedata  (writedata),
        .write      (write),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .readdata   (readdata),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready)
    );

    // Frame sources: beat data = {port, frame index, beat index}
    initial begin
        for (int p = 0; p < 4; p++) begin
            sent[p] = 0;
            beat[p] = 0;
        end
        out_tready = 1'b1;
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tdata   = '0;
        forever begin
            @(negedge clk);
            hs = in_tvalid & in_tready;
            @(posedge clk);
            #1;
            if (tog) out_tready = ~out_tready;
            else     out_tready = 1'b1;
            for (int p = 0; p < 4; p++) begin
                if (!reset_n) begin
                    beat[p] = 0;
                    sent[p] = launched[p];
                end else if (hs[p]) begin
                    if (beat[p] + 1 == src_len[p]) begin
                        beat[p] = 0;
                        sent[p] = sent[p] + 1;
                    end else begin
                        beat[p] = beat[p] + 1;
                    end
                end
                in_tvalid[p] = reset_n && (sent[p] != launched[p]);
                in_tlast[p]  = (beat[p] + 1 == src_len[p]);
                in_tdata[p*16 +: 16] = {2'(p), 6'(sent[p]), 8'(beat[p])};
            end
        end
    end

    // Egress logger: beats, idle cycles between frames, tready rule violations
    initial begin
        viol       = 0;
        after_last = 1'b0;
        idle_run   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                after_last = 1'b0;
                if (out_tvalid || out_tlast || in_tready != 4'b0) viol = viol + 1;
            end else begin
                if (in_tready != 4'b0 && (!$onehot(in_tready) || !out_tready)) viol = viol + 1;
                if (tog && ((in_tready & 4'b1101) != 4'b0 ||
                            (out_tvalid && in_tready[1] != out_tready))) viol = viol + 1;
                if (out_tvalid) begin
                    if (after_last) begin
                        gap_log.push_back(idle_run);
                        after_last = 1'b0;
                    end
                    if (out_tready) begin
                        log_q.push_back({out_tlast, out_tdata});
                        if (out_tlast) begin
                            after_last = 1'b1;
                            idle_run   = 0;
                        end
                    end
                end else if (after_last) begin
                    idle_run = idle_run + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        csr_read(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic launch(input int p, input int unsigned n, input int unsigned len);
        src_len[p]  = len;
        launched[p] = launched[p] + n;
    endtask

    task automatic expect_frame(input int p, input int unsigned frm, input int unsigned len);
        for (int unsigned b = 0; b < len; b++) begin
            exp_q.push_back({(b == len - 1), 2'(p), 6'(frm), 8'(b)});
        end
    endtask

    task automatic wait_log(input int unsigned target, input int unsigned budget, input string tag);
        int unsigned n;
        n = 0;
        while (log_q.size() < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (log_q.size() < target) check(tag, 32'(log_q.size()), 32'(target));
    endtask

    task automatic compare_log(input string tag);
        repeat (10) @(negedge clk);
        #2;
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int unsigned i = cmp_ptr; i < exp_q.size(); i++) begin
            if (i < log_q.size()) check(tag, 32'(log_q[i]), 32'(exp_q[i]));
        end
        cmp_ptr = exp_q.size();
    endtask

    initial begin
        int unsigned b0, b1, b2, b3, lsz;
        logic        hit;
        checks = 0; failures = 0; cmp_ptr = 0; tog = 1'b0;
        for (int p = 0; p < 4; p++) begin
            launched[p] = 0;
            src_len[p]  = 1;
        end
        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_tready", 32'(in_tready), 32'd0);
        check("rst_rdata", 32'(readdata), 32'd0);
        reset_n = 1'b1;

        // Reset register state
        read_check("rst_status", ADDR_STATUS, 8'h00);
        read_check("rst_mask", ADDR_ENABLE, 8'h0F);
        read_check("rst_gap", ADDR_GAP, 8'h00);
        read_check("rst_cnt3", ADDR_COUNT3, 8'h00);

        // Ports 0 and 2 contend, gap 0: port 0 first, one idle cycle between
        @(negedge clk); #2;
        b0 = launched[0]; b2 = launched[2];
        launch(0, 1, 3);
        launch(2, 1, 3);
        expect_frame(0, b0, 3);
        expect_frame(2, b2, 3);
        wait_log(exp_q.size(), 200, "rr_timeout");
        compare_log("rr_beat");
        check("rr_gap", 32'(gap_log[gap_log.size()-1]), 32'd1);
        read_check("rr_cnt0", ADDR_COUNT0, 8'h01);
        read_check("rr_cnt2", ADDR_COUNT2, 8'h01);
        read_check("rr_status", ADDR_STATUS, 8'h02);

        // gap_cycles = 5, two back-to-back frames on port 1: 5 GAP + 1 IDLE
        csr_write(ADDR_GAP, 8'd5);
        read_check("gap_rb", ADDR_GAP, 8'h05);
        @(negedge clk); #2;
        b1 = launched[1];
        launch(1, 2, 2);
        expect_frame(1, b1, 2);
        expect_frame(1, b1 + 1, 2);
        wait_log(exp_q.size(), 200, "gap_timeout");
        compare_log("gap_beat");
        check("gap_idle", 32'(gap_log[gap_log.size()-1]), 32'd6);
        csr_write(ADDR_GAP, 8'd0);

        // out_tready toggles mid-frame on a 6-beat port 1 frame
        @(negedge clk); #2;
        tog = 1'b1;
        b1 = launched[1];
        launch(1, 1, 6);
        expect_frame(1, b1, 6);
        wait_log(exp_q.size(), 200, "tog_timeout");
        tog = 1'b0;
        compare_log("tog_beat");

        // Mask narrowed to port 0 while port 3 is mid-frame
        @(negedge clk); #2;
        b3 = launched[3];
        launch(3, 1, 8);
        expect_frame(3, b3, 8);
        wait_log(cmp_ptr + 2, 200, "mask_start_timeout");
        b0 = launched[0]; b1 = launched[1]; b2 = launched[2];
        launch(0, 1, 2);
        launch(1, 1, 2);
        launch(2, 1, 2);
        csr_write(ADDR_ENABLE, 8'h01);
        expect_frame(0, b0, 2);
        wait_log(exp_q.size(), 200, "mask_timeout");
        compare_log("mask_beat");
        read_check("mask_status", ADDR_STATUS, 8'h00);
        csr_write(ADDR_ENABLE, 8'h0F);
        expect_frame(1, b1, 2);
        expect_frame(2, b2, 2);
        wait_log(exp_q.size(), 200, "drain_timeout");
        compare_log("drain_beat");
        read_check("drain_status", ADDR_STATUS, 8'h02);

        // enable_mask = 0 parks the FSM in IDLE
        csr_write(ADDR_ENABLE, 8'h00);
        @(negedge clk); #2;
        b0 = launched[0];
        launch(0, 1, 2);
        repeat (12) @(negedge clk);
        #2;
        check("mask0_beats", 32'(log_q.size()), 32'(exp_q.size()));
        read_check("mask0_status", ADDR_STATUS, 8'h02);
        csr_write(ADDR_ENABLE, 8'h0F);
        expect_frame(0, b0, 2);
        wait_log(exp_q.size(), 200, "mask0_timeout");
        compare_log("mask0_beat");

        // 256 single-beat frames on port 1: counter wraps to zero
        csr_write(ADDR_CLEAR, 8'h00);
        @(negedge clk); #2;
        b1 = launched[1];
        launch(1, 255, 1);
        for (int unsigned k = 0; k < 255; k++) expect_frame(1, b1 + k, 1);
        wait_log(exp_q.size(), 2000, "wrap_timeout");
        compare_log("wrap_beat");
        read_check("cnt_255", ADDR_COUNT1, 8'hFF);
        read_check("cnt0_clr", ADDR_COUNT0, 8'h00);
        @(negedge clk); #2;
        launch(1, 1, 1);
        expect_frame(1, b1 + 255, 1);
        wait_log(exp_q.size(), 200, "wrap1_timeout");
        compare_log("wrap1_beat");
        read_check("cnt_wrap", ADDR_COUNT1, 8'h00);

        // Clear written on the same edge as a port 0 tlast handshake
        @(negedge clk); #2;
        b0 = launched[0];
        launch(0, 1, 4);
        expect_frame(0, b0, 4);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (out_tvalid && out_tready && out_tlast) hit = 1'b1;
        end
        if (!hit) check("clr_sync_timeout", 32'd0, 32'd1);
        chipselect = 1'b1; write = 1'b1; address = ADDR_CLEAR; writedata = 8'h00;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        compare_log("clr_beat");
        read_check("clr_cnt0", ADDR_COUNT0, 8'h00);
        read_check("clr_cnt1", ADDR_COUNT1, 8'h00);
        read_check("rd_wo_addr", ADDR_CLEAR, 8'h00);
        read_check("rd_unmapped", 8'h08, 8'h00);
        @(negedge clk);
        check("rd_idle", 32'(readdata), 32'd0);

        // Reset asserted mid-frame on port 2
        csr_write(ADDR_GAP, 8'd3);
        csr_write(ADDR_ENABLE, 8'h04);
        @(negedge clk); #2;
        launch(2, 1, 10);
        wait_log(cmp_ptr + 3, 200, "rst_start_timeout");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(out_tvalid), 32'd0);
        check("mid_rst_tlast", 32'(out_tlast), 32'd0);
        check("mid_rst_tready", 32'(in_tready), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lsz = log_q.size();
        read_check("post_status", ADDR_STATUS, 8'h00);
        read_check("post_mask", ADDR_ENABLE, 8'h0F);
        read_check("post_gap", ADDR_GAP, 8'h00);
        read_check("post_cnt2", ADDR_COUNT2, 8'h00);
        repeat (10) @(negedge clk);
        #2;
        check("post_no_beats", 32'(log_q.size()), 32'(lsz));

        check("tready_rules", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
